// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Key-driven integer calculator. A stream of 4-bit tokens (digits, the four
// operators, enter and clear) builds two signed operands of up to three
// decimal digits each. Enter starts one operation. Add and subtract finish
// in one EXEC cycle. Multiply uses a shift-add loop and divide uses a
// restoring shift-subtract loop; each takes 11 EXEC cycles.
//
// Ports
//   clk           in   1   system clock, all state changes on the rising edge
//   rst           in   1   synchronous active-high reset
//   key_valid     in   1   token present on key_code
//   key_code      in   4   0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/',
//                          14 enter, 15 clear
//   key_ready     out  1   high in every state except EXEC
//   busy          out  1   high while in EXEC
//   result        out  11  two's-complement result of the last computation
//   result_valid  out  1   result holds a completed computation
//   err           out  1   last computation overflowed or divided by zero
//   dbg_state_o   out  3   current FSM state (state_e encoding)
//
// Handshake: a token is consumed on a rising edge where key_valid and
// key_ready are both high. While key_ready is low the source must keep
// key_valid and key_code steady; nothing is consumed in EXEC.
// -----------------------------------------------------------------------------
module calc_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic        busy,
    output logic [10:0] result,
    output logic        result_valid,
    output logic        err,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        SIGN1 = 3'd0,
        OPND1 = 3'd1,
        SIGN2 = 3'd2,
        OPND2 = 3'd3,
        EXEC  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_DIV   = 4'd13;
    localparam logic [3:0] KEY_ENTER = 4'd14;
    localparam logic [3:0] KEY_CLEAR = 4'd15;

    // Multiply/divide: steps 0..9 iterate, step 10 finalizes.
    localparam logic [3:0] LAST_STEP = 4'd10;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_e      state_q,  state_d;
    logic [9:0]  opnd1_q,  opnd1_d;
    logic [9:0]  opnd2_q,  opnd2_d;
    logic [1:0]  cnt1_q,   cnt1_d;
    logic [1:0]  cnt2_q,   cnt2_d;
    logic        sign1_q,  sign1_d;
    logic        sign2_q,  sign2_d;
    op_e         op_q,     op_d;
    logic [10:0] result_q, result_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q,    err_d;
    logic [3:0]  step_q,   step_d;
    logic [19:0] acc_q,    acc_d;     // multiply: running product
    logic [19:0] mcand_q,  mcand_d;   // multiply: shifted multiplicand
    logic [9:0]  shift_q,  shift_d;   // multiplier (mul) or quotient (div)
    logic [9:0]  rem_q,    rem_d;     // divide: partial remainder

    // ------------------------------------------------------------------
    // Token decode
    // ------------------------------------------------------------------
    logic key_fire;
    logic is_digit;
    logic is_oper;

    assign key_ready = (state_q != EXEC);
    assign busy      = (state_q == EXEC);
    assign key_fire  = key_valid && key_ready;
    assign is_digit  = (key_code <= 4'd9);
    assign is_oper   = (key_code >= KEY_PLUS) && (key_code <= KEY_DIV);

    // Appends one decimal digit. The caller only does this while fewer
    // than three digits are held (value <= 99), so the result stays <= 999.
    function automatic logic [9:0] push_digit(input logic [9:0] v,
                                              input logic [3:0] d);
        return (v << 3) + (v << 1) + {6'd0, d};
    endfunction

    function automatic op_e decode_op(input logic [3:0] code);
        case (code)
            KEY_MINUS: return OP_SUB;
            KEY_MUL:   return OP_MUL;
            KEY_DIV:   return OP_DIV;
            default:   return OP_ADD;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Add/subtract datapath (combinational, used in the single EXEC cycle)
    // ------------------------------------------------------------------
    logic [11:0] a_s, b_s, sum_s;
    logic        addsub_err;

    assign a_s   = sign1_q ? (12'd0 - {2'b00, opnd1_q}) : {2'b00, opnd1_q};
    assign b_s   = sign2_q ? (12'd0 - {2'b00, opnd2_q}) : {2'b00, opnd2_q};
    assign sum_s = (op_q == OP_SUB) ? (a_s - b_s) : (a_s + b_s);
    // The 12-bit sum fits -1024..1023 only when bits 11 and 10 agree.
    assign addsub_err = sum_s[11] ^ sum_s[10];

    // ------------------------------------------------------------------
    // Divide iteration: shift the next dividend bit into the remainder
    // and subtract the divisor when it fits.
    // ------------------------------------------------------------------
    logic [10:0] div_trial;
    logic [10:0] div_diff;
    logic        div_ge;

    assign div_trial = {rem_q, shift_q[9]};
    assign div_ge    = (div_trial >= {1'b0, opnd2_q});
    assign div_diff  = div_trial - {1'b0, opnd2_q};

    // ------------------------------------------------------------------
    // Multiply/divide finalize: apply the sign and check the range.
    // ------------------------------------------------------------------
    logic [19:0] md_mag;
    logic        md_neg;
    logic        md_err;
    logic [10:0] md_res;

    assign md_mag = (op_q == OP_MUL) ? acc_q : {10'd0, shift_q};
    assign md_neg = sign1_q ^ sign2_q;
    // A negative result may reach magnitude 1024; a positive one only 1023.
    assign md_err = md_neg ? (md_mag > 20'd1024) : (md_mag > 20'd1023);
    // The low 11 bits of -mag equal the negation of the low 11 bits of mag.
    assign md_res = md_neg ? (11'd0 - md_mag[10:0]) : md_mag[10:0];

    logic exec_last;
    assign exec_last = (op_q == OP_ADD) || (op_q == OP_SUB) || (step_q == LAST_STEP);

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        opnd1_d  = opnd1_q;
        opnd2_d  = opnd2_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        op_d     = op_q;
        result_d = result_q;
        rvalid_d = rvalid_q;
        err_d    = err_q;
        step_d   = step_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        shift_d  = shift_q;
        rem_d    = rem_q;

        if (key_fire && (key_code == KEY_CLEAR)) begin
            // Clear is handled identically in every input state; the
            // last result stays visible but is no longer flagged valid.
            state_d  = SIGN1;
            opnd1_d  = '0;
            opnd2_d  = '0;
            cnt1_d   = '0;
            cnt2_d   = '0;
            sign1_d  = 1'b0;
            sign2_d  = 1'b0;
            op_d     = OP_ADD;
            rvalid_d = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                SIGN1: begin
                    if (key_fire) begin
                        // Starting a new expression retires the old result.
                        rvalid_d = 1'b0;
                        err_d    = 1'b0;
                        if (is_digit) begin
                            opnd1_d = {6'd0, key_code};
                            cnt1_d  = 2'd1;
                            sign1_d = 1'b0;
                            state_d = OPND1;
                        end else if ((key_code == KEY_PLUS) || (key_code == KEY_MINUS)) begin
                            opnd1_d = '0;
                            cnt1_d  = '0;
                            sign1_d = (key_code == KEY_MINUS);
                            state_d = OPND1;
                        end
                    end
                end

                OPND1: begin
                    if (key_fire) begin
                        if (is_digit) begin
                            if (cnt1_q != 2'd3) begin
                                opnd1_d = push_digit(opnd1_q, key_code);
                                cnt1_d  = cnt1_q + 2'd1;
                            end
                        end else if (is_oper) begin
                            if (cnt1_q != 2'd0) begin
                                op_d    = decode_op(key_code);
                                opnd2_d = '0;
                                cnt2_d  = '0;
                                sign2_d = 1'b0;
                                state_d = SIGN2;
                            end else if (key_code == KEY_PLUS) begin
                                sign1_d = 1'b0;
                            end else if (key_code == KEY_MINUS) begin
                                sign1_d = 1'b1;
                            end
                        end
                    end
                end

                SIGN2: begin
                    if (key_fire) begin
                        if (is_digit) begin
                            opnd2_d = {6'd0, key_code};
                            cnt2_d  = 2'd1;
                            sign2_d = 1'b0;
                            state_d = OPND2;
                        end else if ((key_code == KEY_PLUS) || (key_code == KEY_MINUS)) begin
                            opnd2_d = '0;
                            cnt2_d  = '0;
                            sign2_d = (key_code == KEY_MINUS);
                            state_d = OPND2;
                        end
                    end
                end

                OPND2: begin
                    if (key_fire) begin
                        if (is_digit) begin
                            if (cnt2_q != 2'd3) begin
                                opnd2_d = push_digit(opnd2_q, key_code);
                                cnt2_d  = cnt2_q + 2'd1;
                            end
                        end else if ((key_code == KEY_ENTER) && (cnt2_q != 2'd0)) begin
                            // Preload both iterative engines; only the one
                            // matching op_q is used.
                            step_d  = '0;
                            acc_d   = '0;
                            mcand_d = {10'd0, opnd1_q};
                            shift_d = (op_q == OP_DIV) ? opnd1_q : opnd2_q;
                            rem_d   = '0;
                            state_d = EXEC;
                        end
                    end
                end

                EXEC: begin
                    step_d = step_q + 4'd1;
                    if (exec_last) begin
                        if ((op_q == OP_ADD) || (op_q == OP_SUB)) begin
                            result_d = sum_s[10:0];
                            err_d    = addsub_err;
                        end else if ((op_q == OP_DIV) && (opnd2_q == 10'd0)) begin
                            result_d = '0;
                            err_d    = 1'b1;
                        end else begin
                            result_d = md_res;
                            err_d    = md_err;
                        end
                        rvalid_d = 1'b1;
                        opnd1_d  = '0;
                        opnd2_d  = '0;
                        cnt1_d   = '0;
                        cnt2_d   = '0;
                        sign1_d  = 1'b0;
                        sign2_d  = 1'b0;
                        state_d  = SIGN1;
                    end else if (op_q == OP_MUL) begin
                        acc_d   = acc_q + (shift_q[0] ? mcand_q : 20'd0);
                        mcand_d = mcand_q << 1;
                        shift_d = shift_q >> 1;
                    end else begin
                        rem_d   = div_ge ? div_diff[9:0] : div_trial[9:0];
                        shift_d = {shift_q[8:0], div_ge};
                    end
                end

                default: begin
                    state_d = SIGN1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SIGN1;
            opnd1_q  <= '0;
            opnd2_q  <= '0;
            cnt1_q   <= '0;
            cnt2_q   <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            op_q     <= OP_ADD;
            result_q <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            step_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            shift_q  <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            opnd1_q  <= opnd1_d;
            opnd2_q  <= opnd2_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            op_q     <= op_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            shift_q  <= shift_d;
            rem_q    <= rem_d;
        end
    end

    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign err          = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
//
// Directed bench for calc_sequencer. Expressions are written as strings:
// '0'-'9' digits, '+', '-', '*', '/', '=' (enter) and 'C' (clear). The
// expected result/err of each expression is pushed into exp_q before it is
// keyed in and popped once result_valid rises.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        busy;
    logic [10:0] result;
    logic        result_valid;
    logic        err;
    logic [2:0]  dbg_state_o;

    always #5 clk = ~clk;

    calc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ready    (key_ready),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .err          (err),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad   = 0;
    logic [11:0] exp_q[$];     // {err, result}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [3:0] key_of(input byte c);
        logic [7:0] d;
        case (c)
            "+":     return 4'd10;
            "-":     return 4'd11;
            "*":     return 4'd12;
            "/":     return 4'd13;
            "=":     return 4'd14;
            "C":     return 4'd15;
            default: begin
                d = c - 8'h30;
                return d[3:0];
            end
        endcase
    endfunction

    // Presents one token at a falling edge and holds it until the rising
    // edge that consumes it; returns 1 ns after that edge.
    task automatic send_key(input logic [3:0] code);
        int n;
        n = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("key_accept", key_ready, 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_key(key_of(s[i]));
    endtask

    // Counts rising edges from the enter edge until result_valid is seen,
    // and how many of the intervening cycles showed busy with key_ready low.
    task automatic wait_result(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        @(negedge clk);
        while (!result_valid && lat < 40) begin
            if (busy && !key_ready) busy_n++;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_expr(input string tag, input string s,
                            input logic [10:0] exp_res, input logic exp_err,
                            input int exp_lat);
        int          lat;
        int          busy_n;
        logic [11:0] item;
        exp_q.push_back({exp_err, exp_res});
        send_str(s);
        wait_result(lat, busy_n);
        item = exp_q.pop_front();
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_n, exp_lat);
        check({tag, "_valid"}, result_valid, 1);
        check({tag, "_result"}, result, item[10:0]);
        check({tag, "_err"}, err, item[11]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int busy_n;

        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_key_ready", key_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state_o, 0);
        rst = 1'b0;

        run_expr("add_basic",  "123+45=",  11'd168,  1'b0, 1);
        run_expr("mul_neg",    "-5*7=",    11'h7DD,  1'b0, 11);
        run_expr("div_zero",   "100/0=",   11'd0,    1'b1, 11);
        run_expr("div_neg",    "-7/2=",    11'h7FD,  1'b0, 11);
        run_expr("mul_ovf",    "999*2=",   11'h7CE,  1'b1, 11);

        // Clear after an overflow: err and valid drop, result is held.
        send_key(4'd15);
        @(negedge clk);
        check("clr_valid", result_valid, 0);
        check("clr_err", err, 0);
        check("clr_result_held", result, 11'h7CE);

        run_expr("add_ovf",    "999+999=", 11'h7CE,  1'b1, 1);
        run_expr("sub_neg",    "5-9=",     11'h7FC,  1'b0, 1);
        run_expr("sub_min",    "-999-25=", 11'h400,  1'b0, 1);
        run_expr("mul_min",    "-512*2=",  11'h400,  1'b0, 11);
        run_expr("mul_1024",   "512*2=",   11'h400,  1'b1, 11);
        run_expr("div_trunc",  "999/7=",   11'd142,  1'b0, 11);
        run_expr("div_negneg", "-9/-3=",   11'd3,    1'b0, 11);
        run_expr("four_digit", "1234+0=",  11'd123,  1'b0, 1);
        run_expr("ignored",    "3=+4*=",   11'd7,    1'b0, 1);
        run_expr("mid_clear",  "12C3+40=", 11'd43,   1'b0, 1);

        // Clear held throughout a multiply: not consumed until EXEC ends.
        send_str("6*7=");
        key_valid = 1'b1;
        key_code  = 4'd15;
        wait_result(lat, busy_n);
        check("hold_latency", lat, 11);
        check("hold_result", result, 11'd42);
        check("hold_valid", result_valid, 1);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        check("hold_valid_pulse", result_valid, 0);
        check("hold_result_kept", result, 11'd42);
        check("hold_state", dbg_state_o, 0);

        // Reset in the 5th EXEC cycle of a divide.
        send_str("8/2=");
        repeat (5) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_state", dbg_state_o, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_ready", key_ready, 1);
        run_expr("post_rst",   "2+3=",     11'd5,    1'b0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
